// File: rtl/temp_ctrl_pkg.sv
// temp_ctrl_pkg: shared state encoding, widths and default thresholds.
// Revision 1.0
`default_nettype none

package temp_ctrl_pkg;

  localparam int SUM_W = 16;
  localparam int CNT_W = 8;
  localparam int AVG_W = 8;

  localparam logic [AVG_W-1:0] DEF_LOW_TH  = 8'd18;
  localparam logic [AVG_W-1:0] DEF_HIGH_TH = 8'd26;
  localparam logic [AVG_W-1:0] DEF_HYST    = 8'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_div_16x8.sv
// seq_div_16x8: restoring divider, one quotient bit per cycle, MSB first.
// Revision 1.0
`default_nettype none

module seq_div_16x8
  import temp_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient,
  output logic [CNT_W-1:0] remainder
);

  logic [SUM_W-1:0] quo_q;
  logic [CNT_W:0]   rem_q;
  logic [CNT_W-1:0] dvs_q;
  logic [3:0]       cnt_q;
  logic             busy_q;

  logic [CNT_W:0]   shifted;
  logic [CNT_W:0]   diff;
  logic             fits;
  logic             unused_rem_msb;

  // Remainder stays below the divisor, so its MSB is only headroom for the trial.
  assign shifted        = {rem_q[CNT_W-1:0], quo_q[SUM_W-1]};
  assign diff           = shifted - {1'b0, dvs_q};
  assign fits           = (shifted >= {1'b0, dvs_q});
  assign unused_rem_msb = rem_q[CNT_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= fits ? diff : shifted;
      quo_q  <= {quo_q[SUM_W-2:0], fits};
      cnt_q  <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == 4'd15);
  assign quotient  = quo_q;
  assign remainder = rem_q[CNT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/temp_avg_controller.sv
// temp_avg_controller: sequential sensor averaging with a hysteresis thermostat.
// Revision 1.0
`default_nettype none

module temp_avg_controller
  import temp_ctrl_pkg::*;
#(
  parameter logic [AVG_W-1:0] LOW_TH  = DEF_LOW_TH,
  parameter logic [AVG_W-1:0] HIGH_TH = DEF_HIGH_TH,
  parameter logic [AVG_W-1:0] HYST    = DEF_HYST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [SUM_W-1:0] temp_sum_i,
  input  logic [CNT_W-1:0] nr_active_sensors_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AVG_W-1:0] temp_avg_o,
  output logic             div_err_o,
  output logic             heat_o,
  output logic             cool_o
);

  localparam logic [AVG_W:0]   HEAT_REL = {1'b0, LOW_TH} + {1'b0, HYST};
  localparam logic [AVG_W-1:0] COOL_REL = HIGH_TH - HYST;

  if (int'(LOW_TH) + int'(HYST) > int'(HIGH_TH) - int'(HYST)) begin : g_bad_thresholds
    $error("temp_avg_controller: LOW_TH + HYST must not exceed HIGH_TH - HYST");
  end

  state_t           state, next_state;
  logic             err_pending;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_quo;
  logic [CNT_W-1:0] div_rem;
  logic [AVG_W-1:0] avg_new;
  logic             unused_div;

  assign div_start  = (state == IDLE) && start_i && (nr_active_sensors_i != '0);
  assign avg_new    = (|div_quo[SUM_W-1:AVG_W]) ? '1 : div_quo[AVG_W-1:0];
  assign unused_div = div_busy ^ (^div_rem);

  seq_div_16x8 u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (div_start),
    .dividend  (temp_sum_i),
    .divisor   (nr_active_sensors_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // An error request spends one cycle in DIV so it reports after the same edge
  // count as the division's first step.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_i) next_state = DIV;
      DIV:     if (err_pending || div_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pending <= 1'b0;
      temp_avg_o  <= '0;
      div_err_o   <= 1'b0;
      heat_o      <= 1'b0;
      cool_o      <= 1'b0;
    end else begin
      if (state == IDLE && start_i) err_pending <= (nr_active_sensors_i == '0);
      if (state == DONE) begin
        if (err_pending) begin
          temp_avg_o <= '0;
          div_err_o  <= 1'b1;
        end else begin
          temp_avg_o <= avg_new;
          div_err_o  <= 1'b0;
          if (avg_new < LOW_TH)                 heat_o <= 1'b1;
          else if ({1'b0, avg_new} >= HEAT_REL) heat_o <= 1'b0;
          if (avg_new > HIGH_TH)                cool_o <= 1'b1;
          else if (avg_new <= COOL_REL)         cool_o <= 1'b0;
        end
      end
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_temp_avg_controller.sv
// tb_temp_avg_controller: scoreboard bench for the averaging controller.
// Revision 1.0
`default_nettype none

module tb_temp_avg_controller;

  localparam int LOW_TH  = 18;
  localparam int HIGH_TH = 26;
  localparam int HYST    = 2;

  typedef struct {
    logic [7:0]  avg;
    logic        err;
    logic        heat;
    logic        cool;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] temp_sum_i;
  logic [7:0]  nr_active_sensors_i;
  logic        busy_o, done_o, div_err_o, heat_o, cool_o;
  logic [7:0]  temp_avg_o;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        chk_pending = 1'b0;
  logic        mh = 1'b0;
  logic        mc = 1'b0;

  temp_avg_controller dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .temp_sum_i          (temp_sum_i),
    .nr_active_sensors_i (nr_active_sensors_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .temp_avg_o          (temp_avg_o),
    .div_err_o           (div_err_o),
    .heat_o              (heat_o),
    .cool_o              (cool_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] s, input logic [7:0] n);
    exp_t e;
    int   q;
    if (n == 8'd0) begin
      e.avg = 8'd0;
      e.err = 1'b1;
    end else begin
      q     = int'(s) / int'(n);
      e.avg = (q > 255) ? 8'hFF : q[7:0];
      e.err = 1'b0;
      if (int'(e.avg) < LOW_TH)              mh = 1'b1;
      else if (int'(e.avg) >= LOW_TH + HYST) mh = 1'b0;
      if (int'(e.avg) > HIGH_TH)             mc = 1'b1;
      else if (int'(e.avg) <= HIGH_TH - HYST) mc = 1'b0;
    end
    e.heat = mh;
    e.cool = mc;
    e.acc  = 0;
    e.lat  = (n == 8'd0) ? 1 : 16;
    return e;
  endfunction

  // Latency is checked on the done pulse; results one cycle later.
  always @(negedge clk_i) begin
    if (chk_pending) begin
      check("avg",  {24'd0, temp_avg_o}, {24'd0, cur.avg});
      check("err",  {31'd0, div_err_o},  {31'd0, cur.err});
      check("heat", {31'd0, heat_o},     {31'd0, cur.heat});
      check("cool", {31'd0, cool_o},     {31'd0, cur.cool});
      chk_pending = 1'b0;
    end
    if (done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        cur = sb.pop_front();
        check("latency", cyc - cur.acc, cur.lat);
        chk_pending = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [15:0] s, input logic [7:0] n);
    exp_t e;
    @(negedge clk_i);
    start_i             = 1'b1;
    temp_sum_i          = s;
    nr_active_sensors_i = n;
    @(posedge clk_i);
    #1;
    start_i             = 1'b0;
    temp_sum_i          = 16'($urandom);
    nr_active_sensors_i = 8'($urandom);
    e     = model(s, n);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i);
      if (sb.size() == 0 && !chk_pending) break;
    end
    check("drain", sb.size() + {31'd0, chk_pending}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   ndone;
    int unsigned t0;

    rst_i = 1'b1; start_i = 1'b0; temp_sum_i = '0; nr_active_sensors_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", {31'd0, busy_o},     32'd0);
    check("rst_done", {31'd0, done_o},     32'd0);
    check("rst_avg",  {24'd0, temp_avg_o}, 32'd0);
    check("rst_err",  {31'd0, div_err_o},  32'd0);
    check("rst_heat", {31'd0, heat_o},     32'd0);
    check("rst_cool", {31'd0, cool_o},     32'd0);

    do_req(16'd100, 8'd5);  drain();
    do_req(16'd103, 8'd4);  drain();
    do_req(16'd135, 8'd5);  drain();
    do_req(16'd125, 8'd5);  drain();
    do_req(16'd500, 8'd0);  drain();
    do_req(16'd96,  8'd4);  drain();

    // Continuous start: accepts every 18 cycles, only two finish inside the window.
    @(negedge clk_i);
    start_i = 1'b1; temp_sum_i = 16'd85; nr_active_sensors_i = 8'd5;
    @(posedge clk_i);
    #1 t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e     = model(16'd85, 8'd5);
      e.acc = t0 + 18 * k;
      sb.push_back(e);
    end
    ndone = 0;
    for (int i = 0; i < 39; i++) begin
      @(negedge clk_i);
      ndone += int'(done_o);
    end
    start_i = 1'b0;
    check("burst_dones", ndone, 32'd2);
    drain();

    // Abort in the 8th DIV cycle.
    do_req(16'd200, 8'd5);
    repeat (7) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    sb.delete();
    mh = 1'b0; mc = 1'b0;
    @(negedge clk_i);
    check("abort_busy", {31'd0, busy_o},     32'd0);
    check("abort_done", {31'd0, done_o},     32'd0);
    check("abort_avg",  {24'd0, temp_avg_o}, 32'd0);
    check("abort_err",  {31'd0, div_err_o},  32'd0);
    check("abort_heat", {31'd0, heat_o},     32'd0);
    check("abort_cool", {31'd0, cool_o},     32'd0);
    repeat (20) @(negedge clk_i);

    do_req(16'd60,   8'd3);  drain();
    do_req(16'd1275, 8'd5);  drain();
    do_req(16'd300,  8'd1);  drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
